secded_inject_pipe: RTL and testbench
=====================================

Name: secded_inject_pipe

Overview:
Parametrised, pipelined SECDED channel: encodes K-bit data into an extended Hamming codeword, applies programmable single- or double-bit error injection, then decodes, corrects and flags the result.
- Replaces the random-injection combinational test block with a deterministic, flow-controlled two-stage pipeline.
- Adds saturating error counters for ECC characterisation in the RISC-V memory path.

Parameters:
K, 32, data width in bits (>=4)
M, derived, smallest m with 2**m >= m+K+1 (K=8 -> 4; K=32 -> 6)
N, derived, M+K; codeword bits are indexed 0..N
PW, derived, $clog2(N+1), width of injection position fields
CNT_W, 16, width of each error counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
valid_i  in  1  input word valid
ready_o  out  1  block can accept input
data_i  in  K  data to encode
inj_mode_i  in  2  0 none, 1 single flip, 2 double flip, 3 reserved (treated as none); sampled with data_i
inj_pos0_i  in  PW  first flip position, 0..N
inj_pos1_i  in  PW  second flip position, 0..N
valid_o  out  1  output word valid
ready_i  in  1  downstream ready
data_o  out  K  decoded/corrected data
sb_err_o  out  1  single-bit error detected (corrected)
db_err_o  out  1  uncorrectable error detected
sb_fix_o  out  1  correction changed a data bit
syndrome_o  out  M+1  [M:1] Hamming syndrome s, [0] overall parity check p
cnt_clr_i  in  1  synchronous clear of both counters
sb_cnt_o  out  CNT_W  saturating count of sb_err outputs
db_cnt_o  out  CNT_W  saturating count of db_err outputs

Behaviour:
- Codeword layout: parity bits at power-of-two positions 1,2,4,...; data bits in ascending order at the remaining positions 1..N (data_i[0] at position 3). Bit 0 is overall even parity over bits 1..N.
- Stage 1 (S1): on an input handshake (valid_i && ready_o), registers the encoded codeword XOR the injection mask.
  - Mode 1 flips inj_pos0_i.
  - Mode 2 flips inj_pos0_i and inj_pos1_i; equal positions cancel (no net flip).
  - Any position >N flips nothing.
- Stage 2 (S2): registers the decode of S1, giving data_o, flags and syndrome_o.
  - s = XOR of the indices of all set bits in 1..N.
  - p = XOR of bits 0..N.
- Decode rules:
  - s=0, p=0: clean, all flags 0.
  - p=1, s in 1..N: flip bit s, sb_err=1; sb_fix=1 only if s is not a power of two.
  - p=1, s=0: parity bit 0 in error; sb_err=1, sb_fix=0.
  - p=1, s>N: db_err=1, no correction.
  - p=0, s!=0: db_err=1; data_o is the uncorrected extracted data.
  - sb_err and db_err are never both 1.
- Flow control:
  - S2 advances when S2 is empty or valid_o && ready_i.
  - S1 advances into S2 under the same condition.
  - ready_o = !S1_valid || S1 advancing.
  - Latency is 2 cycles from input handshake to valid_o with no backpressure; throughput is 1 word/cycle.
  - Outputs are held stable while valid_o && !ready_i. Order is preserved and nothing is dropped or duplicated.
- Counters:
  - Increment on an output handshake with sb_err_o / db_err_o set; saturate at 2**CNT_W-1.
  - cnt_clr_i has priority over a same-cycle increment; result is 0.
- Reset (async assert, any time including mid-transfer):
  - S1/S2 valid = 0, valid_o = 0, data_o = 0, all flags = 0, syndrome_o = 0, both counters = 0.
  - ready_o = 1 once rst_ni is deasserted.
  - In-flight words are discarded.

Test Plan:
- K=8 (M=4, N=12), data_i=0xA5, mode 0, ready_i=1 -> valid_o 2 cycles later, data_o=0xA5, all flags 0, syndrome_o=0x00.
- 0xA5, mode 1, pos0=3 -> data_o=0xA5, sb_err=1, sb_fix=1, syndrome_o=0x07. Same with pos0=4 -> sb_fix=0, syndrome_o=0x09. Same with pos0=0 -> sb_err=1, sb_fix=0, syndrome_o=0x01.
- 0xA5, mode 2, pos0=3, pos1=5 -> db_err=1, sb_err=0, syndrome_o=0x0C. pos0=pos1=6 -> clean, flags 0. pos0=13, mode 1 -> clean.
- Backpressure: ready_i=0, stream 0x11, 0x22, 0x33 -> ready_o falls after 2 accepts. Raise ready_i -> outputs 0x11, 0x22, 0x33 in order, each held stable while stalled.
- CNT_W=2: five single-error words -> sb_cnt_o=3 (saturated). cnt_clr_i with a concurrent sb word -> sb_cnt_o=0. Two double-error words -> db_cnt_o=2.
- Assert rst_ni low with both stages full -> valid_o=0 and counters=0 immediately (asynchronous). After release, ready_o=1 and the first new word appears with 2-cycle latency.

Source files
------------

// File: rtl/secded_inject_pipe.sv
// rtl/secded_inject_pipe.sv - two-stage SECDED encode / error-inject / decode pipeline
// with flow control and saturating single/double error counters.
`timescale 1ns/1ps
module secded_inject_pipe #(
  parameter int K     = 32,
  parameter int CNT_W = 16,
  localparam int M  = (K <= 1)   ? 2 :
                      (K <= 4)   ? 3 :
                      (K <= 11)  ? 4 :
                      (K <= 26)  ? 5 :
                      (K <= 57)  ? 6 :
                      (K <= 120) ? 7 :
                      (K <= 247) ? 8 : 9,
  localparam int N  = M + K,
  localparam int PW = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [K-1:0]     data_i,
  input  logic [1:0]       inj_mode_i,
  input  logic [PW-1:0]    inj_pos0_i,
  input  logic [PW-1:0]    inj_pos1_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [K-1:0]     data_o,
  output logic             sb_err_o,
  output logic             db_err_o,
  output logic             sb_fix_o,
  output logic [M:0]       syndrome_o,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] sb_cnt_o,
  output logic [CNT_W-1:0] db_cnt_o
);

  function automatic logic is_pow2(input int v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Data bits fill the non-power-of-two positions in ascending order; each
  // parity bit is the matching bit of the XOR of the set data positions.
  function automatic logic [N:0] encode(input logic [K-1:0] d);
    logic [N:0]   cw;
    logic [M-1:0] s;
    int           j;
    cw = '0;
    s  = '0;
    j  = 0;
    for (int i = 1; i <= N; i++) begin
      if (!is_pow2(i)) begin
        cw[i] = d[j];
        if (d[j]) s ^= M'(i);
        j++;
      end
    end
    for (int b = 0; b < M; b++) cw[1 << b] = s[b];
    cw[0] = ^cw[N:1];
    return cw;
  endfunction

  function automatic logic [K-1:0] extract(input logic [N:0] cw);
    logic [K-1:0] d;
    int           j;
    d = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if (!is_pow2(i)) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  logic             s1_valid;
  logic             s2_valid;
  logic [N:0]       s1_cw;
  logic [N:0]       enc_cw;
  logic [N:0]       mask0;
  logic [N:0]       mask1;
  logic [N:0]       inj_mask;
  logic [N:0]       corr_cw;
  logic [M-1:0]     dec_s;
  logic             dec_p;
  logic             s_in_range;
  logic [K-1:0]     dec_data;
  logic             dec_sb;
  logic             dec_db;
  logic             dec_fix;
  logic             s2_adv;
  logic             out_hs;
  logic [CNT_W-1:0] cnt_max;

  assign enc_cw  = encode(data_i);
  assign s2_adv  = !s2_valid || (valid_o && ready_i);
  assign ready_o = !s1_valid || s2_adv;
  assign valid_o = s2_valid;
  assign out_hs  = valid_o && ready_i;
  assign cnt_max = '1;

  // Positions above N match no bit, so out-of-range requests flip nothing.
  always_comb begin
    mask0 = '0;
    mask1 = '0;
    for (int i = 0; i <= N; i++) begin
      mask0[i] = (inj_pos0_i == PW'(i));
      mask1[i] = (inj_pos1_i == PW'(i));
    end
    case (inj_mode_i)
      2'd1:    inj_mask = mask0;
      2'd2:    inj_mask = mask0 ^ mask1;
      default: inj_mask = '0;
    endcase
  end

  always_comb begin
    dec_s = '0;
    for (int i = 1; i <= N; i++) begin
      if (s1_cw[i]) dec_s ^= M'(i);
    end
    dec_p      = ^s1_cw;
    s_in_range = (dec_s <= M'(N));
    corr_cw    = s1_cw;
    if (dec_p && (dec_s != '0) && s_in_range) corr_cw[dec_s] = ~s1_cw[dec_s];
    dec_data = extract(corr_cw);
    dec_sb   = dec_p && s_in_range;
    dec_db   = (dec_p && !s_in_range) || (!dec_p && (dec_s != '0));
    dec_fix  = dec_p && (dec_s != '0) && s_in_range && !is_pow2(int'(dec_s));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) s1_cw <= enc_cw ^ inj_mask;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid   <= 1'b0;
      data_o     <= '0;
      sb_err_o   <= 1'b0;
      db_err_o   <= 1'b0;
      sb_fix_o   <= 1'b0;
      syndrome_o <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_o     <= dec_data;
        sb_err_o   <= dec_sb;
        db_err_o   <= dec_db;
        sb_fix_o   <= dec_fix;
        syndrome_o <= {dec_s, dec_p};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      sb_cnt_o <= '0;
      db_cnt_o <= '0;
    end else if (out_hs) begin
      if (sb_err_o && (sb_cnt_o != cnt_max)) sb_cnt_o <= sb_cnt_o + 1'b1;
      if (db_err_o && (db_cnt_o != cnt_max)) db_cnt_o <= db_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_secded_inject_pipe.sv
// tb/tb_secded_inject_pipe.sv - vector table, hand sequences and a randomized
// error-pattern reference model for secded_inject_pipe (K=8, CNT_W=2).
`timescale 1ns/1ps
module tb_secded_inject_pipe;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic [1:0] inj_mode_i;
  logic [3:0] inj_pos0_i;
  logic [3:0] inj_pos1_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic       sb_err_o;
  logic       db_err_o;
  logic       sb_fix_o;
  logic [4:0] syndrome_o;
  logic       cnt_clr_i;
  logic [1:0] sb_cnt_o;
  logic [1:0] db_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  secded_inject_pipe #(.K(8), .CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .data_i(data_i), .inj_mode_i(inj_mode_i), .inj_pos0_i(inj_pos0_i),
    .inj_pos1_i(inj_pos1_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .sb_err_o(sb_err_o), .db_err_o(db_err_o),
    .sb_fix_o(sb_fix_o), .syndrome_o(syndrome_o), .cnt_clr_i(cnt_clr_i),
    .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
  );

  typedef struct {
    logic [7:0] d;
    logic [1:0] mode;
    logic [3:0] p0;
    logic [3:0] p1;
    logic [7:0] ed;
    logic       sb;
    logic       db;
    logic       fix;
    logic [4:0] syn;
  } vec_t;

  typedef struct {
    logic [7:0] ed;
    logic       sb;
    logic       db;
    logic       fix;
    logic [4:0] syn;
  } exp_t;

  vec_t vt[14];
  int   dpos[8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: classify by the set of net flipped positions, not by decoding.
  function automatic exp_t model(input logic [7:0] d, input logic [1:0] mode,
                                 input int p0, input int p1);
    exp_t e;
    int   q[$];
    e = '{d, 1'b0, 1'b0, 1'b0, 5'd0};
    if (mode == 2'd1 && p0 <= 12) q.push_back(p0);
    if (mode == 2'd2 && p0 != p1) begin
      if (p0 <= 12) q.push_back(p0);
      if (p1 <= 12) q.push_back(p1);
    end
    if (q.size() == 1) begin
      e.sb  = 1'b1;
      e.syn = {q[0][3:0], 1'b1};
      for (int k = 0; k < 8; k++) if (dpos[k] == q[0]) e.fix = 1'b1;
    end else if (q.size() == 2) begin
      e.db  = 1'b1;
      e.syn = {4'(q[0] ^ q[1]), 1'b0};
      foreach (q[n]) for (int k = 0; k < 8; k++) if (dpos[k] == q[n]) e.ed[k] = ~e.ed[k];
    end
    return e;
  endfunction

  // Hands one word in with ready_i=1 and returns with it showing on valid_o.
  task automatic xfer(input logic [7:0] d, input logic [1:0] mode,
                      input logic [3:0] p0, input logic [3:0] p1, output int lat);
    int n;
    ready_i    = 1'b1;
    valid_i    = 1'b1;
    data_i     = d;
    inj_mode_i = mode;
    inj_pos0_i = p0;
    inj_pos1_i = p1;
    n = 0;
    while (!ready_o && n < 20) begin tick(); n++; end
    tick();
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin tick(); lat++; end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    xfer(v.d, v.mode, v.p0, v.p1, lat);
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_data"}, data_o, v.ed);
    chk({nm, "_flags"}, {sb_err_o, db_err_o, sb_fix_o}, {v.sb, v.db, v.fix});
    chk({nm, "_syn"}, syndrome_o, v.syn);
    tick();
  endtask

  initial begin
    logic [7:0] got[$];
    exp_t       sbq[$];
    exp_t       e;
    int         lat;
    int         msb;
    int         mdb;
    logic       in_hs;
    logic       out_hs;

    vt[0]  = '{8'hA5, 2'd0, 4'd0,  4'd0,  8'hA5, 1'b0, 1'b0, 1'b0, 5'h00};
    vt[1]  = '{8'hA5, 2'd1, 4'd3,  4'd0,  8'hA5, 1'b1, 1'b0, 1'b1, 5'h07};
    vt[2]  = '{8'hA5, 2'd1, 4'd4,  4'd0,  8'hA5, 1'b1, 1'b0, 1'b0, 5'h09};
    vt[3]  = '{8'hA5, 2'd1, 4'd0,  4'd0,  8'hA5, 1'b1, 1'b0, 1'b0, 5'h01};
    vt[4]  = '{8'hA5, 2'd2, 4'd3,  4'd5,  8'hA6, 1'b0, 1'b1, 1'b0, 5'h0C};
    vt[5]  = '{8'hA5, 2'd2, 4'd6,  4'd6,  8'hA5, 1'b0, 1'b0, 1'b0, 5'h00};
    vt[6]  = '{8'hA5, 2'd1, 4'd13, 4'd0,  8'hA5, 1'b0, 1'b0, 1'b0, 5'h00};
    vt[7]  = '{8'hA5, 2'd3, 4'd3,  4'd5,  8'hA5, 1'b0, 1'b0, 1'b0, 5'h00};
    vt[8]  = '{8'hA5, 2'd1, 4'd12, 4'd0,  8'hA5, 1'b1, 1'b0, 1'b1, 5'h19};
    vt[9]  = '{8'hA5, 2'd2, 4'd0,  4'd1,  8'hA5, 1'b0, 1'b1, 1'b0, 5'h02};
    vt[10] = '{8'hA5, 2'd2, 4'd1,  4'd2,  8'hA5, 1'b0, 1'b1, 1'b0, 5'h06};
    vt[11] = '{8'hFF, 2'd1, 4'd7,  4'd0,  8'hFF, 1'b1, 1'b0, 1'b1, 5'h0F};
    vt[12] = '{8'h00, 2'd2, 4'd13, 4'd5,  8'h00, 1'b1, 1'b0, 1'b1, 5'h0B};
    vt[13] = '{8'h3C, 2'd2, 4'd9,  4'd12, 8'hAC, 1'b0, 1'b1, 1'b0, 5'h0A};

    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    inj_mode_i = '0; inj_pos0_i = '0; inj_pos1_i = '0; cnt_clr_i = 1'b0;
    tick(); tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_outs", {data_o, sb_err_o, db_err_o, sb_fix_o, syndrome_o}, 0);
    chk("rst_cnts", {sb_cnt_o, db_cnt_o}, 0);
    rst_ni = 1'b1;
    #1;
    chk("rst_ready", ready_o, 1);

    for (int i = 0; i < 14; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: two words fill the pipe, the third must wait.
    ready_i = 1'b0; valid_i = 1'b1; inj_mode_i = 2'd0; data_i = 8'h11;
    #1; chk("bp_ready0", ready_o, 1);
    tick(); data_i = 8'h22;
    #1; chk("bp_ready1", ready_o, 1);
    tick(); data_i = 8'h33;
    #1; chk("bp_ready_fall", ready_o, 0);
    tick(); chk("bp_hold0", {valid_o, data_o}, {1'b1, 8'h11});
    tick(); chk("bp_hold1", {valid_o, data_o}, {1'b1, 8'h11});
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      in_hs = valid_i && ready_o;
      if (valid_o && ready_i) got.push_back(data_o);
      tick();
      if (in_hs) valid_i = 1'b0;
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("bp_order%0d", i), (got.size() > i) ? got[i] : 8'hXX, 8'h11 * (i + 1));

    // Counter saturation and clear priority.
    cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
    for (int i = 0; i < 5; i++) begin xfer(8'h5A, 2'd1, 4'd3, 4'd0, lat); tick(); end
    chk("sb_cnt_sat", sb_cnt_o, 3);
    xfer(8'h5A, 2'd1, 4'd5, 4'd0, lat);
    cnt_clr_i = 1'b1; tick(); cnt_clr_i = 1'b0;
    chk("sb_cnt_clr", sb_cnt_o, 0);
    for (int i = 0; i < 2; i++) begin xfer(8'h5A, 2'd2, 4'd3, 4'd5, lat); tick(); end
    chk("db_cnt_two", db_cnt_o, 2);
    chk("sb_cnt_after_db", sb_cnt_o, 0);

    // Asynchronous reset with both stages occupied.
    ready_i = 1'b0; valid_i = 1'b1; inj_mode_i = 2'd0; data_i = 8'h44;
    tick(); data_i = 8'h55; tick(); valid_i = 1'b0;
    chk("full_before_rst", valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_data", data_o, 0);
    chk("arst_cnts", {sb_cnt_o, db_cnt_o}, 0);
    tick(); rst_ni = 1'b1;
    #1; chk("arst_ready", ready_o, 1);
    run_vec('{8'hC3, 2'd0, 4'd0, 4'd0, 8'hC3, 1'b0, 1'b0, 1'b0, 5'h00}, "post_rst");

    // Randomized traffic against the error-pattern model.
    cnt_clr_i = 1'b1; ready_i = 1'b1; tick(); cnt_clr_i = 1'b0;
    msb = 0; mdb = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c < 1400) begin
        valid_i    = ($urandom_range(0, 9) < 7);
        data_i     = 8'($urandom);
        inj_mode_i = 2'($urandom);
        inj_pos0_i = 4'($urandom);
        inj_pos1_i = ($urandom_range(0, 3) == 0) ? inj_pos0_i : 4'($urandom);
        ready_i    = ($urandom_range(0, 9) < 7);
      end else begin
        valid_i = 1'b0;
        ready_i = 1'b1;
      end
      #1;
      in_hs  = valid_i && ready_o;
      out_hs = valid_o && ready_i;
      if (out_hs) begin
        if (sbq.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rnd_data", data_o, e.ed);
          chk("rnd_flags", {sb_err_o, db_err_o, sb_fix_o}, {e.sb, e.db, e.fix});
          chk("rnd_syn", syndrome_o, e.syn);
          if (e.sb && msb < 3) msb++;
          if (e.db && mdb < 3) mdb++;
        end
      end
      if (in_hs) sbq.push_back(model(data_i, inj_mode_i, int'(inj_pos0_i), int'(inj_pos1_i)));
      tick();
    end
    chk("rnd_drained", sbq.size(), 0);
    chk("rnd_sb_cnt", sb_cnt_o, msb);
    chk("rnd_db_cnt", db_cnt_o, mdb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
